write_channel_gate_mc: RTL

Parametrised, multi-channel successor to the single-channel AXI W-channel delayer in the axi_node write path. For each of NUM_CH write channels it masks WVALID/WREADY toward the slave-side FIFO logic:
- after the channel FIFO drains, letting the draining beat through once;
- for a programmable number of cycles after each FIFO read-enable.

It also flags handshakes it suppressed and, optionally, keeps per-channel statistics.

---
 rtl/write_channel_gate_mc.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/write_channel_gate_mc.sv
// -----------------------------------------------------------------------------
// write_channel_gate_mc
//
// Multi-channel AXI W-channel gate for the axi_node write path. For each of
// NUM_CH channels the raw WVALID/WREADY pair is masked toward the slave-side
// FIFO logic:
//   - while the channel FIFO stays empty (the beat that drains it still passes),
//   - for HOLD_CYCLES cycles after each FIFO read-enable.
// Suppressed handshakes raise a sticky per-channel error flag.
//
// Optional feature: define WCHAN_GATE_STATS_EN to build per-channel saturating
// counters of accepted beats and masked cycles. Without it the statistics
// outputs are constant 0 and no counter flops exist.
// -----------------------------------------------------------------------------
module write_channel_gate_mc #(
    parameter int NUM_CH      = 4,   // independent write channels (1..16)
    parameter int HOLD_CYCLES = 1,   // masked cycles after a read-enable (1..15)
    parameter int STAT_W      = 16   // statistics counter width
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          empty,
    input  logic [NUM_CH-1:0]          r_enable,
    input  logic [NUM_CH-1:0]          m_WVALID,
    input  logic [NUM_CH-1:0]          m_WREADY,
    input  logic                       bypass,
    input  logic                       err_clr,
    output logic [NUM_CH-1:0]          m_WVALID_out,
    output logic [NUM_CH-1:0]          m_WREADY_out,
    output logic [NUM_CH-1:0]          gated,
    output logic [NUM_CH-1:0]          err_suppr,
    output logic [NUM_CH*STAT_W-1:0]   stat_beats,
    output logic [NUM_CH*STAT_W-1:0]   stat_blocked
);

    // Reload value for the hold counter; the counter is 4 bits wide.
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES);

    // Per-channel state.
    logic [NUM_CH-1:0] r_empty_q;              // empty seen last cycle
    logic [3:0]        r_hold_cnt [NUM_CH];    // remaining masked cycles
    logic [NUM_CH-1:0] r_err_suppr;            // sticky suppressed-handshake flag

    // Combinational decisions.
    logic [NUM_CH-1:0] w_mask;                 // mask decision before bypass
    logic [NUM_CH-1:0] w_gated;                // final per-channel mask
    logic [NUM_CH-1:0] w_suppr;                // handshake masked this cycle
    logic [NUM_CH-1:0] w_beat;                 // handshake accepted this cycle

    // Track the previous empty level; reset to "was empty" so an empty FIFO
    // is masked straight out of reset rather than treated as a draining edge.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of block ordering.
        if (rst) begin
            r_empty_q <= '1;
        end else begin
            r_empty_q <= empty;
        end
    end

    // Hold counter: a read-enable (re)loads HOLD_CYCLES, otherwise count to 0.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the hold counters are a handful of control flops, not a RAM,
        // so they are cleared by reset; this also abandons any hold in flight.
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_hold_cnt[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_enable[i]) begin
                    r_hold_cnt[i] <= HOLD_LOAD;
                end else if (r_hold_cnt[i] != 4'd0) begin
                    r_hold_cnt[i] <= r_hold_cnt[i] - 4'd1;
                end
            end
        end
    end

    // Mask decision: the empty rules take priority over the hold counter.
    always_comb begin
        // NOTE: default every bit first so no path leaves w_mask unassigned,
        // which would otherwise infer a latch.
        w_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (empty[i]) begin
                // Falling into empty passes the draining beat once, then masks.
                w_mask[i] = r_empty_q[i];
            end else begin
                w_mask[i] = (r_hold_cnt[i] != 4'd0);
            end
        end
    end

    // Bypass only affects the outputs; the state above keeps updating.
    assign w_gated      = bypass ? '0 : w_mask;
    assign w_suppr      = w_gated & m_WVALID & m_WREADY;
    assign w_beat       = ~w_gated & m_WVALID & m_WREADY;

    assign m_WVALID_out = m_WVALID & ~w_gated;
    assign m_WREADY_out = m_WREADY & ~w_gated;
    assign gated        = w_gated;
    assign err_suppr    = r_err_suppr;

    // Sticky error flag: a new suppression in the same cycle as err_clr wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_suppr <= '0;
        end else begin
            r_err_suppr <= (r_err_suppr & ~{NUM_CH{err_clr}}) | w_suppr;
        end
    end

`ifdef WCHAN_GATE_STATS_EN

    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [STAT_W-1:0] r_stat_beats   [NUM_CH];
    logic [STAT_W-1:0] r_stat_blocked [NUM_CH];

    // Saturating statistics counters; only rst clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_stat_beats[i]   <= '0;
                r_stat_blocked[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_beat[i] && (r_stat_beats[i] != STAT_MAX)) begin
                    r_stat_beats[i] <= r_stat_beats[i] + 1'b1;
                end
                if (w_gated[i] && (r_stat_blocked[i] != STAT_MAX)) begin
                    r_stat_blocked[i] <= r_stat_blocked[i] + 1'b1;
                end
            end
        end
    end

    // Pack the per-channel counters onto the flat output buses.
    always_comb begin
        stat_beats   = '0;
        stat_blocked = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            stat_beats[i*STAT_W +: STAT_W]   = r_stat_beats[i];
            stat_blocked[i*STAT_W +: STAT_W] = r_stat_blocked[i];
        end
    end

`else

    // Statistics not built: the accepted-beat term has no consumer.
    logic w_beat_unused;
    assign w_beat_unused = ^w_beat;

    assign stat_beats   = '0;
    assign stat_blocked = '0;

`endif

endmodule
